instr_loader: RTL and testbench
===============================

# instr_loader

Write-side companion to the byte-organised instruction memory. Accepts 32-bit instruction words over a valid/ready stream and writes each one into the memory's byte write port over four cycles, little-endian (byte 0 of the word to the lowest address). Holds the core in reset until the first load session completes, so the PC-indexed fetch never reads unloaded memory.

## Interface
- ADDR_W, 5, byte-address width of the instruction memory; the memory holds 2^ADDR_W bytes.
- CNT_W, ADDR_W-1, width of num_words; must be able to encode 2^(ADDR_W-2).

- clk  in  1  single clock; all state changes on the rising edge.
- reset_n  in  1  synchronous, active-low reset.
- start  in  1  single-cycle request to begin a load session; sampled only in IDLE.
- base_addr  in  ADDR_W  first byte address of the session; bits [1:0] are ignored and treated as 0.
- num_words  in  CNT_W  number of words in the session; sampled with start.
- in_valid  in  1  in_word is valid.
- in_ready  out  1  loader can accept a word this cycle.
- in_word  in  32  instruction word; transfer occurs when in_valid and in_ready are both 1 at an edge.
- mem_we  out  1  byte write strobe to the instruction memory.
- mem_addr  out  ADDR_W  byte write address.
- mem_wdata  out  8  byte write data.
- busy  out  1  session in progress: any state other than IDLE.
- done  out  1  one-cycle pulse when a session ends.
- core_reset  out  1  active-high reset for the core.

## Operation
- States: IDLE, WAIT_WORD, WRITE, DONE. Internal registers: addr (ADDR_W), remaining (CNT_W), word (32), byte_idx (2), loaded (1).
- IDLE
  - in_ready=0, mem_we=0.
  - start=1 and num_words≠0: addr←{base_addr[ADDR_W-1:2],2'b00}, remaining←num_words, then go to WAIT_WORD.
  - start=1 and num_words=0: go to DONE. No writes occur.
- WAIT_WORD
  - in_ready=1.
  - On a transfer: word←in_word, byte_idx←0, then go to WRITE.
- WRITE
  - in_ready=0, mem_we=1.
  - mem_addr=addr+byte_idx, computed modulo 2^ADDR_W.
  - mem_wdata=word[8*byte_idx+7 : 8*byte_idx].
  - byte_idx increments each cycle.
  - After byte_idx=3:
    - addr←addr+4, modulo 2^ADDR_W. Wrap from the top address to 0 is legal and silent.
    - remaining←remaining-1.
    - If the new remaining is 0, go to DONE; otherwise go to WAIT_WORD.
- DONE
  - done=1, loaded←1, then go to IDLE.
- Outputs are decoded from registered state only; no combinational path from in_valid to any output.
- start while busy=1 is ignored. It is not queued.
- in_word is consumed only on a transfer. in_valid while in_ready=0 has no effect, and the upstream must hold the word.
- core_reset = ~loaded | busy. It is 1 from reset until the first done, and 1 again during any later session.

## Timing
- Reset (reset_n=0 at an edge): state=IDLE, addr=0, remaining=0, byte_idx=0, word=0, loaded=0.
  - Resulting outputs: in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, core_reset=1.
- Reset mid-session: takes effect at the next edge. No further mem_we. Memory bytes already written are untouched. core_reset returns to 1.
- Session startup:
  - start sampled at edge T.
  - busy=1 and in_ready=1 from T+1.
- Word write sequence:
  - A transfer at edge E gives mem_we=1 for the four cycles following E, E+1..E+4.
  - Addresses in those cycles are addr, addr+1, addr+2, addr+3.
- Next step after a word:
  - If words remain, in_ready=1 again in the cycle after E+4.
  - If it was the last word, done=1 in that cycle.
- Throughput: at most 1 word per 5 cycles. Upstream stalls stretch WAIT_WORD without limit.
- Session length: N words with zero stall take 5N+1 cycles from start to the done cycle inclusive, plus the start cycle.
- done is exactly one cycle. busy falls in the cycle after done.

## Test plan
- Single word, base 0:
  - Stimulus: start with num_words=1, then in_word=0x00940333.
  - Required: writes 0x33@0, 0x03@1, 0x94@2, 0x00@3 on four consecutive cycles; done one cycle later; core_reset falls with busy.
- Unaligned base and wrap:
  - Stimulus: base_addr=30 (treated as 28), num_words=2, words 0x0000006F and 0x413903B3.
  - Required: writes bytes 0x6F,0x00,0x00,0x00 @28..31, then 0xB3,0x03,0x39,0x41 @0..3.
- Backpressure:
  - Stimulus: in_valid low for 7 cycles after start, then 0x035A02B3.
  - Required: in_ready stays 1 with no mem_we during the wait; then 4 writes @0..3; total session 6+7 cycles after start.
- Zero-length session:
  - Stimulus: start with num_words=0.
  - Required: done at T+1, no mem_we, in_ready never 1, loaded=1.
- Start while busy:
  - Stimulus: a second start with base 16 during WRITE of a session at base 0.
  - Required: ignored; all writes stay at 0..3; exactly one done pulse.
- Reset mid-session:
  - Stimulus: reset_n=0 after the 2nd byte write of a word.
  - Required: no further mem_we, state IDLE, core_reset=1; a following full session completes normally.

Source files
------------

// File: rtl/instr_loader.sv
// instr_loader: streams 32-bit instruction words into a byte-wide instruction
// memory write port, little-endian, one byte per cycle. Holds the core in
// reset until the first load session has finished.
module instr_loader #(
  parameter int ADDR_W = 5,
  parameter int CNT_W  = ADDR_W - 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  num_words,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_word,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              core_reset
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_WORD = 2'd1,
    WRITE     = 2'd2,
    DONE      = 2'd3
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [ADDR_W-1:0]   addr;
  logic [CNT_W-1:0]    remaining;
  logic [31:0]         word;
  logic [1:0]          byte_idx;
  logic                loaded;
  logic [31:0]         word_shift;

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state decode and outputs; outputs depend on registered state only
  always_comb begin
    state_nxt  = state;
    in_ready   = 1'b0;
    mem_we     = 1'b0;
    busy       = (state != IDLE);
    done       = 1'b0;
    core_reset = ~loaded | (state != IDLE);
    mem_addr   = addr + {{(ADDR_W-2){1'b0}}, byte_idx};
    word_shift = word >> {byte_idx, 3'b000};
    mem_wdata  = word_shift[7:0];
    case (state)
      IDLE: begin
        if (start) state_nxt = (num_words == '0) ? DONE : WAIT_WORD;
      end
      WAIT_WORD: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = WRITE;
      end
      WRITE: begin
        mem_we = 1'b1;
        // remaining still holds the pre-decrement count on the last byte
        if (byte_idx == 2'd3)
          state_nxt = (remaining == CNT_W'(1)) ? DONE : WAIT_WORD;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath registers: session address/count, current word, byte cursor
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      addr      <= '0;
      remaining <= '0;
      word      <= '0;
      byte_idx  <= '0;
      loaded    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start && (num_words != '0)) begin
            addr      <= {base_addr[ADDR_W-1:2], 2'b00};
            remaining <= num_words;
          end
        end
        WAIT_WORD: begin
          if (in_valid) begin
            word     <= in_word;
            byte_idx <= '0;
          end
        end
        WRITE: begin
          byte_idx <= byte_idx + 2'd1;
          if (byte_idx == 2'd3) begin
            addr      <= addr + ADDR_W'(4);
            remaining <= remaining - CNT_W'(1);
          end
        end
        DONE: begin
          loaded <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_loader.sv
// Self-checking bench for instr_loader: directed scenarios plus randomized
// sessions, checked against a queue-based model of the expected byte writes.
module tb_instr_loader;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [4:0]  base_addr;
  logic [3:0]  num_words;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_word;
  logic        mem_we;
  logic [4:0]  mem_addr;
  logic [7:0]  mem_wdata;
  logic        busy;
  logic        done;
  logic        core_reset;

  int checks   = 0;
  int failures = 0;

  logic [31:0] words_q[$];
  int          stall_q[$];
  logic [12:0] exp_q[$];
  logic [12:0] obs_q[$];
  int          done_cnt = 0;
  int          inject_cyc = -1;

  instr_loader #(.ADDR_W(5), .CNT_W(4)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .base_addr  (base_addr),
    .num_words  (num_words),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_word    (in_word),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .busy       (busy),
    .done       (done),
    .core_reset (core_reset)
  );

  always #5 clk = ~clk;

  // Record every byte write and done pulse seen on the memory side
  always @(negedge clk) begin
    if (mem_we) obs_q.push_back({mem_addr, mem_wdata});
    if (done) done_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: word w, byte b lands at aligned base + 4w + b (mod 32)
  task automatic build_exp(input logic [4:0] base, input int n);
    int unsigned a;
    exp_q.delete();
    for (int w = 0; w < n; w++)
      for (int b = 0; b < 4; b++) begin
        a = ((int'(base) / 4) * 4 + 4 * w + b) % 32;
        exp_q.push_back({5'(a), 8'((words_q[w] >> (8 * b)) & 32'hFF)});
      end
  endtask

  task automatic run_session(input string name, input logic [4:0] base, input int n);
    int cyc, idx, stall, total_stall, done_cyc, limit;
    total_stall = 0;
    for (int i = 0; i < n; i++) total_stall += stall_q[i];
    build_exp(base, n);
    obs_q.delete();
    done_cnt = 0;
    @(negedge clk);
    start = 1'b1; base_addr = base; num_words = 4'(n); in_valid = 1'b0;
    cyc = 0; idx = 0; done_cyc = -1; stall = (n > 0) ? stall_q[0] : 0;
    limit = 5 * n + 1 + total_stall + 20;
    while (done_cyc < 0 && cyc < limit) begin
      @(negedge clk);
      cyc++;
      if (cyc == inject_cyc) begin
        start = 1'b1; base_addr = 5'd16; num_words = 4'd2;
      end else begin
        start = 1'b0;
      end
      if (cyc == 1) chk({name, "_ready_t1"}, {31'b0, in_ready}, {31'b0, n != 0});
      if (in_ready && mem_we) chk({name, "_ready_and_we"}, 32'd1, 32'd0);
      if (n == 0 && in_ready) chk({name, "_zero_ready"}, 32'd1, 32'd0);
      if (!busy) chk({name, "_busy_drop"}, {31'b0, busy}, 32'd1);
      if (done) done_cyc = cyc;
      if (in_ready && idx < n) begin
        if (stall > 0) begin
          in_valid = 1'b0; in_word = $urandom; stall--;
        end else begin
          in_valid = 1'b1; in_word = words_q[idx]; idx++;
          stall = (idx < n) ? stall_q[idx] : 0;
        end
      end else begin
        in_valid = 1'($urandom); in_word = $urandom;
      end
    end
    chk({name, "_done_cycle"}, done_cyc, 5 * n + 1 + total_stall);
    @(negedge clk);
    in_valid = 1'b0;
    chk({name, "_post_busy"}, {31'b0, busy}, 32'd0);
    chk({name, "_post_done"}, {31'b0, done}, 32'd0);
    chk({name, "_core_reset"}, {31'b0, core_reset}, 32'd0);
    chk({name, "_done_pulses"}, done_cnt, 1);
    chk({name, "_nwrites"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      chk($sformatf("%s_write%0d", name, i), {19'b0, obs_q[i]}, {19'b0, exp_q[i]});
  endtask

  initial begin
    int wcnt, n;
    logic [4:0] b;
    reset_n = 1'b0; start = 1'b0; base_addr = '0; num_words = '0;
    in_valid = 1'b0; in_word = '0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
    chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
    chk("rst_mem_addr", {27'b0, mem_addr}, 32'd0);
    chk("rst_mem_wdata", {24'b0, mem_wdata}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_core_reset", {31'b0, core_reset}, 32'd1);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_core_reset", {31'b0, core_reset}, 32'd1);

    words_q = '{32'h00940333}; stall_q = '{0};
    run_session("single", 5'd0, 1);

    words_q = '{32'h0000006F, 32'h413903B3}; stall_q = '{0, 0};
    run_session("wrap", 5'd30, 2);

    words_q = '{32'h035A02B3}; stall_q = '{7};
    run_session("bp", 5'd0, 1);

    words_q.delete(); stall_q.delete();
    run_session("zero", 5'd12, 0);

    words_q = '{$urandom}; stall_q = '{0};
    inject_cyc = 3;
    run_session("busy_start", 5'd0, 1);
    inject_cyc = -1;
    repeat (8) @(negedge clk);
    chk("busy_start_ignored", {31'b0, busy}, 32'd0);

    // Reset after the second byte write of a word
    obs_q.delete();
    @(negedge clk);
    start = 1'b1; base_addr = 5'd8; num_words = 4'd1;
    @(negedge clk);
    start = 1'b0; in_valid = 1'b1; in_word = $urandom;
    wcnt = 0;
    for (int i = 0; i < 20 && wcnt < 2; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      if (mem_we) wcnt++;
    end
    chk("mid_two_writes", wcnt, 2);
    reset_n = 1'b0;
    @(negedge clk);
    chk("mid_we", {31'b0, mem_we}, 32'd0);
    chk("mid_busy", {31'b0, busy}, 32'd0);
    chk("mid_core_reset", {31'b0, core_reset}, 32'd1);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("mid_total_writes", obs_q.size(), 2);
    chk("mid_idle_core_reset", {31'b0, core_reset}, 32'd1);

    words_q = '{$urandom, $urandom}; stall_q = '{1, 0};
    run_session("after_rst", 5'd4, 2);

    for (int s = 0; s < 6; s++) begin
      n = int'($urandom_range(0, 8));
      b = 5'($urandom);
      words_q.delete(); stall_q.delete();
      for (int i = 0; i < n; i++) begin
        words_q.push_back($urandom);
        stall_q.push_back(int'($urandom_range(0, 3)));
      end
      run_session($sformatf("rand%0d", s), b, n);
      repeat (int'($urandom_range(0, 2))) @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
